// File: rtl/alu_result_fifo.sv
// Circular result queue between alu32 and writeback, valid/ready on both sides.
// Optional sticky overflow flag: define ALU_RESULT_FIFO_STICKY_OVF_EN.
module alu_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
    input  logic             ovf_clear,
    output logic             ovf_sticky,
`endif
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_out,
    input  logic             in_overflow,
    input  logic             in_zero,
    input  logic             in_negative,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_negative,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             ovf;
        logic             zero;
        logic             neg;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head         = mem[rd_ptr];
    assign out_data     = head.data;
    assign out_overflow = head.ovf;
    assign out_zero     = head.zero;
    assign out_negative = head.neg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= '{data: in_out, ovf: in_overflow,
                             zero: in_zero, neg: in_negative};
        end
    end

    // Flush wins over any push or pop in the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
    logic ovf_set;
    logic ovf_clr;

    assign ovf_set = push & in_overflow & ~flush;
    assign ovf_clr = ovf_clear | flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= ovf_set | (ovf_sticky & ~ovf_clr);
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: ordering, full/empty, flush, reset.
// Sticky overflow checks build only with ALU_RESULT_FIFO_STICKY_OVF_EN.
module tb_alu_result_fifo;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_out;
    logic        in_overflow;
    logic        in_zero;
    logic        in_negative;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_overflow;
    logic        out_zero;
    logic        out_negative;
    logic [2:0]  count;
`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
    logic        ovf_clear;
    logic        ovf_sticky;
`endif

    int checks = 0;
    int errors = 0;

    alu_result_fifo #(.WIDTH(32), .DEPTH(4), .PTR_W(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
        .ovf_clear   (ovf_clear),
        .ovf_sticky  (ovf_sticky),
`endif
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_out      (in_out),
        .in_overflow (in_overflow),
        .in_zero     (in_zero),
        .in_negative (in_negative),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_overflow(out_overflow),
        .out_zero    (out_zero),
        .out_negative(out_negative),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic o, input logic z, input logic n);
        in_valid    = v;
        in_out      = d;
        in_overflow = o;
        in_zero     = z;
        in_negative = n;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if ({out_data, out_overflow, out_zero, out_negative} !== 35'd0) begin
            errors++;
            $display("FAIL reset_out_bus got %h want 0",
                     {out_data, out_overflow, out_zero, out_negative});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_overflow, out_zero, out_negative, count}
            !== {1'b1, 32'h0000000C, 3'b000, 3'd1}) begin
            errors++;
            $display("FAIL single_head got v=%b d=%h f=%b%b%b c=%0d want v=1 d=0000000c f=000 c=1",
                     out_valid, out_data, out_overflow, out_zero, out_negative, count);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL single_pop got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL empty_pop_ignored got c=%0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({count, out_data, out_zero, out_negative}
            !== {3'd2, 32'hFFFFFFFD, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_head0 got c=%0d d=%h z=%b n=%b want c=2 d=fffffffd z=0 n=1",
                     count, out_data, out_zero, out_negative);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({count, out_data, out_zero, out_negative}
            !== {3'd1, 32'h00000000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_head1 got c=%0d d=%h z=%b n=%b want c=1 d=0 z=1 n=0",
                     count, out_data, out_zero, out_negative);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_drain got c=%0d want 0", count);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++;
        if ({count, in_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_state got c=%0d rdy=%b want c=4 rdy=0", count, in_ready);
        end
        drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_reject got c=%0d want 4", count);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if ({count, in_ready} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL full_pop got c=%0d rdy=%b want c=3 rdy=1", count, in_ready);
        end
        drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, 32'(i)}) begin
                errors++;
                $display("FAIL wrap_order got v=%b d=%0d want v=1 d=%0d",
                         out_valid, out_data, i);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_drain got c=%0d want 0", count);
        end
    endtask

    task automatic test_concurrent();
        for (int i = 10; i <= 11; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(12 + i), 1'b0, 1'b0, 1'b0);
            checks++;
            if (out_data !== 32'(10 + i)) begin
                errors++;
                $display("FAIL conc_order got d=%0d want %0d", out_data, 10 + i);
            end
            step();
            checks++;
            if (count !== 3'd2) begin
                errors++;
                $display("FAIL conc_count got c=%0d want 2", count);
            end
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 16; i <= 17; i++) begin
            checks++;
            if (out_data !== 32'(i)) begin
                errors++;
                $display("FAIL conc_tail got d=%0d want %0d", out_data, i);
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 20; i <= 22; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre got c=%0d want 3", count);
        end
        flush = 1'b1;
        drive(1'b1, 32'd99, 1'b0, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_clear got c=%0d v=%b rdy=%b want c=0 v=0 rdy=1",
                     count, out_valid, in_ready);
        end
        for (int i = 30; i <= 32; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({count, out_data} !== {3'd3, 32'd30}) begin
            errors++;
            $display("FAIL flush_after got c=%0d d=%0d want c=3 d=30", count, out_data);
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, count, out_data, out_overflow, out_zero, out_negative}
            !== {1'b0, 1'b1, 3'd0, 32'd0, 3'b000}) begin
            errors++;
            $display("FAIL async_reset got v=%b rdy=%b c=%0d d=%h want v=0 rdy=1 c=0 d=0",
                     out_valid, in_ready, count, out_data);
        end
        #1;
        reset_n = 1'b1;
        drive(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({count, out_data, out_overflow} !== {3'd1, 32'd7, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_push got c=%0d d=%0d o=%b want c=1 d=7 o=1",
                     count, out_data, out_overflow);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
    task automatic test_sticky();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_init got %b want 0", ovf_sticky);
        end
        drive(1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if ({ovf_sticky, out_data, out_negative} !== {1'b1, 32'h80000000, 1'b1}) begin
            errors++;
            $display("FAIL sticky_set got s=%b d=%h want s=1 d=80000000", ovf_sticky, out_data);
        end
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear got %b want 0", ovf_sticky);
        end
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
        ovf_clear = 1'b0;
`endif
        step();
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_concurrent();
        test_flush();
        test_async_reset();
`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
